gpmc_bram_arbiter: RTL and testbench
====================================

// Module: gpmc_bram_arbiter
// PURPOSE
//  Shares the single port of the 2K x 16 block RAM between two requesters:
//  port 0 (GPMC SRAM controller, host side) and port 1 (fabric-side engine).
//  Fixed priority to port 0, with a starvation limit that guarantees port 1 progress.
//  Sits between the requesters and bram2k_x_16bit; drives its a_ena/a_wr/a_addr/a_din.
// PARAMETERS
//  AW          11  address width (words)
//  DW          16  data width
//  STARVE_MAX   4  consecutive contested port-0 grants before port 1 is forced in (>=1)
// PORTS
//  a_clk       in   1   single clock, same clock as the BRAM port
//  a_rst_n     in   1   asynchronous reset, active low
//  pN_req      in   1   N=0,1: access request; held with wr/addr/din until pN_ack
//  pN_wr       in   1   1=write, 0=read
//  pN_addr     in   AW  word address
//  pN_din      in   DW  write data
//  pN_ack      out  1   one-cycle pulse: request issued to BRAM
//  pN_rvalid   out  1   one-cycle pulse: pN_rdata valid (reads only)
//  pN_rdata    out  DW  read data; holds last value until the next read on that port
//  mem_ena     out  1   BRAM enable
//  mem_wr      out  1   BRAM write enable
//  mem_addr    out  AW  BRAM address
//  mem_din     out  DW  BRAM write data
//  mem_dout    in   DW  BRAM read data, 1-cycle latency after the enable edge
//  busy        out  1   high in any state other than IDLE
// BEHAVIOUR
//  - Reset: every output 0, state IDLE, starvation counter 0, latched grant cleared.
//  - All outputs are registered. FSM: IDLE -> ISSUE -> (RDATA ->) IDLE.
//  - IDLE: requests are sampled only here. Select the winner, register mem_ena=1,
//    mem_wr, mem_addr, mem_din and latch the grant. Go to ISSUE. With no request,
//    stay in IDLE with mem_ena=0.
//  - ISSUE: mem_* is valid and pW_ack=1 for the winner W. The BRAM captures on the
//    edge that ends ISSUE. That edge clears mem_ena/mem_wr. Next state is RDATA if
//    read, IDLE if write.
//  - RDATA: on the edge that ends RDATA, pW_rdata<=mem_dout and pW_rvalid<=1 for one
//    cycle. Go to IDLE.
//  - Latency from req first seen in IDLE (cycle 0): ack in cycle 1.
//    For a read, rvalid in cycle 3. Throughput: 1 write per 2 cycles, 1 read per 3.
//  - Requester rule: drop req (or present the next request) on the edge where ack=1.
//    A req still high in the next IDLE cycle is a new access.
//  - Arbitration:
//    - Only p0_req: p0. Only p1_req: p1.
//    - Both: p1 if starve_cnt==STARVE_MAX, else p0.
//    - starve_cnt increments on each p0 grant while p1_req=1, saturating at STARVE_MAX.
//    - starve_cnt clears on a p1 grant, or in any IDLE cycle with p1_req=0.
//  - Requester input changes outside IDLE are ignored. Address is not range-checked;
//    the full AW space maps to the BRAM.
//  - Reset mid-access: the access is abandoned. A pending rvalid is never emitted.
//    The BRAM write may or may not have occurred; requesters must re-issue.
// CONFIGURATION
//  GPMC_ARB_WP_EN defined:
//    - Adds input wp (1) and output p0_wp_err (1, reset 0).
//    - A port-0 write in IDLE with wp=1 is granted and acked normally, but mem_ena and
//      mem_wr stay 0 (no BRAM write).
//    - p0_wp_err pulses with p0_ack.
//    - Port-1 writes and all reads are unaffected.
//  GPMC_ARB_WP_EN undefined: wp and p0_wp_err ports are absent; all writes are performed.
// TESTING
//  1. p0 write addr 0x005 data 0xBEEF, then p0 read 0x005 -> ack cycle 1; rvalid cycle 3
//     with p0_rdata=0xBEEF.
//  2. p0 and p1 read in the same IDLE cycle -> p0 acked first, p1 acked in the next
//     ISSUE cycle; both rdata correct.
//  3. p0_req held continuously, p1_req held, STARVE_MAX=4 -> p1 acked after exactly
//     4 p0 grants; counter resets.
//  4. p1 write 0x7FF=0x1234 (top address) then read -> 0x1234; mem_addr=0x7FF, no wrap.
//  5. a_rst_n low during ISSUE of a read -> all outputs 0 immediately, no rvalid after
//     release, FSM IDLE.
//  6. GPMC_ARB_WP_EN, wp=1, p0 write 0x010=0xAAAA -> p0_ack and p0_wp_err pulse,
//     mem_ena stays 0, later read returns the old value.

Source files
------------

// File: rtl/gpmc_bram_arbiter.sv
// Two-port arbiter in front of the single-port 2K x 16 block RAM.
// Port 0 (GPMC host side) has fixed priority. A starvation counter forces port 1 in
// after STARVE_MAX consecutive contested port-0 grants.
// Optional write protect for port 0 is enabled by defining GPMC_ARB_WP_EN.
module gpmc_bram_arbiter #(
  parameter int unsigned AW         = 11,
  parameter int unsigned DW         = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          a_clk,
  input  logic          a_rst_n,
  input  logic          p0_req,
  input  logic          p0_wr,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_din,
  output logic          p0_ack,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_wr,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_din,
  output logic          p1_ack,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_ena,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
`ifdef GPMC_ARB_WP_EN
  input  logic          wp,
  output logic          p0_wp_err,
`endif
  output logic          busy
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] StarveMax = CW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIssue, StRdata} state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;   // 1: port 1 owns the current access
  logic            rd_q, rd_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            mem_ena_q, mem_ena_d;
  logic            mem_wr_q, mem_wr_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_din_q, mem_din_d;
  logic            p0_ack_q, p0_ack_d;
  logic            p1_ack_q, p1_ack_d;
  logic            p0_rvalid_q, p0_rvalid_d;
  logic            p1_rvalid_q, p1_rvalid_d;
  logic [DW-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DW-1:0]   p1_rdata_q, p1_rdata_d;
  logic            busy_q, busy_d;
  logic            sel_p1;
  logic            wp_block;
`ifdef GPMC_ARB_WP_EN
  logic            wp_err_q, wp_err_d;
`endif

  // Arbitration, next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rd_d        = rd_q;
    starve_d    = starve_q;
    mem_ena_d   = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
`ifdef GPMC_ARB_WP_EN
    wp_err_d    = 1'b0;
`endif
    sel_p1 = p1_req && (!p0_req || (starve_q == StarveMax));
`ifdef GPMC_ARB_WP_EN
    // Protected port-0 write: acked normally but never reaches the BRAM
    wp_block = !sel_p1 && p0_req && p0_wr && wp;
`else
    wp_block = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (!p1_req || sel_p1) begin
          starve_d = '0;
        end else if (starve_q != StarveMax) begin
          starve_d = starve_q + 1'b1;
        end
        if (p0_req || p1_req) begin
          state_d    = StIssue;
          grant_d    = sel_p1;
          rd_d       = sel_p1 ? !p1_wr : !p0_wr;
          mem_ena_d  = !wp_block;
          mem_wr_d   = (sel_p1 ? p1_wr : p0_wr) && !wp_block;
          mem_addr_d = sel_p1 ? p1_addr : p0_addr;
          mem_din_d  = sel_p1 ? p1_din : p0_din;
          p0_ack_d   = !sel_p1;
          p1_ack_d   = sel_p1;
`ifdef GPMC_ARB_WP_EN
          wp_err_d   = wp_block;
`endif
        end
      end
      StIssue: begin
        state_d = rd_q ? StRdata : StIdle;
      end
      StRdata: begin
        state_d = StIdle;
        if (grant_q) begin
          p1_rvalid_d = 1'b1;
          p1_rdata_d  = mem_dout;
        end else begin
          p0_rvalid_d = 1'b1;
          p0_rdata_d  = mem_dout;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      rd_q        <= 1'b0;
      starve_q    <= '0;
      mem_ena_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      busy_q      <= 1'b0;
`ifdef GPMC_ARB_WP_EN
      wp_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rd_q        <= rd_d;
      starve_q    <= starve_d;
      mem_ena_q   <= mem_ena_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      busy_q      <= busy_d;
`ifdef GPMC_ARB_WP_EN
      wp_err_q    <= wp_err_d;
`endif
    end
  end

  assign mem_ena   = mem_ena_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign busy      = busy_q;
`ifdef GPMC_ARB_WP_EN
  assign p0_wp_err = wp_err_q;
`endif

endmodule

// File: tb/tb_gpmc_bram_arbiter.sv
// Scoreboard bench for gpmc_bram_arbiter with a behavioural 2K x 16 BRAM model.
// Stimulus pushes expected acks/read data; a negedge monitor pops and compares.
module tb_gpmc_bram_arbiter;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;

  logic          a_clk = 1'b0;
  logic          a_rst_n = 1'b0;
  logic          p0_req = 1'b0, p0_wr = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_din = '0;
  logic          p0_ack, p0_rvalid;
  logic [DW-1:0] p0_rdata;
  logic          p1_req = 1'b0, p1_wr = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_din = '0;
  logic          p1_ack, p1_rvalid;
  logic [DW-1:0] p1_rdata;
  logic          mem_ena, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic          busy;
`ifdef GPMC_ARB_WP_EN
  logic          wp = 1'b0;
  logic          p0_wp_err;
`endif

  gpmc_bram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .a_clk     (a_clk),
    .a_rst_n   (a_rst_n),
    .p0_req    (p0_req),
    .p0_wr     (p0_wr),
    .p0_addr   (p0_addr),
    .p0_din    (p0_din),
    .p0_ack    (p0_ack),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_wr     (p1_wr),
    .p1_addr   (p1_addr),
    .p1_din    (p1_din),
    .p1_ack    (p1_ack),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .mem_ena   (mem_ena),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
`ifdef GPMC_ARB_WP_EN
    .wp        (wp),
    .p0_wp_err (p0_wp_err),
`endif
    .busy      (busy)
  );

  always #5 a_clk = ~a_clk;

  // Behavioural BRAM: 1-cycle read latency
  logic [DW-1:0] mem [0:2047];
  always @(posedge a_clk) begin
    if (mem_ena) begin
      if (mem_wr) mem[mem_addr] <= mem_din;
      mem_dout <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge a_clk) cyc <= cyc + 1;

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic          wr;
    logic          ena;
    logic          wperr;
  } ack_t;

  ack_t          exp_ack[$];
  logic [DW-1:0] exp_rd0[$];
  logic [DW-1:0] exp_rd1[$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            ack_cyc[2];
  int            rv_cyc[2];
  ack_t          mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ack_t mk(input int port, input logic [AW-1:0] addr, input logic wr,
                              input logic ena, input logic wperr);
    ack_t e;
    e.port = port; e.addr = addr; e.wr = wr; e.ena = ena; e.wperr = wperr;
    return e;
  endfunction

  // Monitor: pops expectations whenever the DUT presents an ack or rvalid
  always @(negedge a_clk) begin
    if (a_rst_n) begin
      if (mem_ena) check("ena_with_ack", 32'(p0_ack | p1_ack), 32'd1);
      if (p0_ack || p1_ack) begin
        check("ack_onehot", 32'(p0_ack & p1_ack), 32'd0);
        if (exp_ack.size() == 0) begin
          check("ack_expected_depth", 32'(exp_ack.size()), 32'd1);
        end else begin
          mon_e = exp_ack.pop_front();
          check("ack_port", 32'(p1_ack), 32'(mon_e.port));
          check("ack_mem_addr", 32'(mem_addr), 32'(mon_e.addr));
          check("ack_mem_wr", 32'(mem_wr), 32'(mon_e.wr));
          check("ack_mem_ena", 32'(mem_ena), 32'(mon_e.ena));
          check("ack_busy", 32'(busy), 32'd1);
`ifdef GPMC_ARB_WP_EN
          check("ack_wp_err", 32'(p0_wp_err), 32'(mon_e.wperr));
`endif
          ack_cyc[p1_ack ? 1 : 0] = cyc;
        end
      end
      if (p0_rvalid) begin
        if (exp_rd0.size() == 0) check("rvalid0_expected_depth", 32'(exp_rd0.size()), 32'd1);
        else check("p0_rdata", 32'(p0_rdata), 32'(exp_rd0.pop_front()));
        rv_cyc[0] = cyc;
      end
      if (p1_rvalid) begin
        if (exp_rd1.size() == 0) check("rvalid1_expected_depth", 32'(exp_rd1.size()), 32'd1);
        else check("p1_rdata", 32'(p1_rdata), 32'(exp_rd1.pop_front()));
        rv_cyc[1] = cyc;
      end
    end
  end

  // Present one request on a port, hold it until ack, drop it on the ack edge
  task automatic access(input int port, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] din, output int start);
    bit got = 0;
    @(posedge a_clk); #1;
    start = cyc;
    if (port == 0) begin
      p0_req = 1'b1; p0_wr = wr; p0_addr = addr; p0_din = din;
    end else begin
      p1_req = 1'b1; p1_wr = wr; p1_addr = addr; p1_din = din;
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge a_clk);
      if ((port == 0) ? p0_ack : p1_ack) begin
        got = 1;
        break;
      end
    end
    if (!got) check("ack_timeout", 32'(got), 32'd1);
    @(posedge a_clk); #1;
    if (port == 0) p0_req = 1'b0;
    else p1_req = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      if (exp_ack.size() + exp_rd0.size() + exp_rd1.size() == 0) break;
      @(negedge a_clk);
    end
    check("drain_pending", 32'(exp_ack.size() + exp_rd0.size() + exp_rd1.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s0, s1, p0_cnt, p1_cnt, p0_first, p0_between;
    // Reset state
    #2;
    check("rst_ctrl", 32'({mem_ena, mem_wr, p0_ack, p1_ack, p0_rvalid, p1_rvalid, busy}),
          32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_rdata", 32'({p0_rdata, p1_rdata}), 32'd0);
    #20 a_rst_n = 1'b1;
    repeat (3) @(posedge a_clk);

    // 1: write then read on port 0, latency check
    exp_ack.push_back(mk(0, 11'h005, 1'b1, 1'b1, 1'b0));
    access(0, 1'b1, 11'h005, 16'hBEEF, s);
    drain();
    check("t1_wr_ack_lat", 32'(ack_cyc[0] - s), 32'd1);
    exp_ack.push_back(mk(0, 11'h005, 1'b0, 1'b1, 1'b0));
    exp_rd0.push_back(16'hBEEF);
    access(0, 1'b0, 11'h005, 16'h0000, s);
    drain();
    check("t1_rd_ack_lat", 32'(ack_cyc[0] - s), 32'd1);
    check("t1_rvalid_lat", 32'(rv_cyc[0] - s), 32'd3);

    // 2: simultaneous reads, port 0 first
    exp_ack.push_back(mk(1, 11'h100, 1'b1, 1'b1, 1'b0));
    access(1, 1'b1, 11'h100, 16'hCAFE, s);
    drain();
    exp_ack.push_back(mk(0, 11'h005, 1'b0, 1'b1, 1'b0));
    exp_ack.push_back(mk(1, 11'h100, 1'b0, 1'b1, 1'b0));
    exp_rd0.push_back(16'hBEEF);
    exp_rd1.push_back(16'hCAFE);
    fork
      access(0, 1'b0, 11'h005, 16'h0000, s0);
      access(1, 1'b0, 11'h100, 16'h0000, s1);
    join
    drain();
    check("t2_p0_ack_lat", 32'(ack_cyc[0] - s0), 32'd1);
    check("t2_p1_ack_lat", 32'(ack_cyc[1] - s1), 32'd4);

    // 3: both held continuously; p1 forced in after 4 contested p0 grants, twice
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) exp_ack.push_back(mk(0, 11'h020, 1'b1, 1'b1, 1'b0));
      exp_ack.push_back(mk(1, 11'h021, 1'b1, 1'b1, 1'b0));
    end
    @(posedge a_clk); #1;
    p0_req = 1'b1; p0_wr = 1'b1; p0_addr = 11'h020; p0_din = 16'h1111;
    p1_req = 1'b1; p1_wr = 1'b1; p1_addr = 11'h021; p1_din = 16'h2222;
    p0_cnt = 0; p1_cnt = 0; p0_first = -1; p0_between = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge a_clk);
      if (p0_ack) p0_cnt++;
      if (p1_ack) begin
        p1_cnt++;
        if (p1_cnt == 1) begin
          p0_first = p0_cnt;
          p0_cnt = 0;
        end else begin
          p0_between = p0_cnt;
          break;
        end
      end
    end
    @(posedge a_clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    drain();
    check("t3_p0_grants_first", 32'(p0_first), 32'd4);
    check("t3_p0_grants_after_reset", 32'(p0_between), 32'd4);

    // 4: top address, no wrap onto address 0
    exp_ack.push_back(mk(0, 11'h000, 1'b1, 1'b1, 1'b0));
    access(0, 1'b1, 11'h000, 16'h5555, s);
    exp_ack.push_back(mk(1, 11'h7FF, 1'b1, 1'b1, 1'b0));
    access(1, 1'b1, 11'h7FF, 16'h1234, s);
    exp_ack.push_back(mk(1, 11'h7FF, 1'b0, 1'b1, 1'b0));
    exp_rd1.push_back(16'h1234);
    access(1, 1'b0, 11'h7FF, 16'h0000, s);
    drain();
    exp_ack.push_back(mk(0, 11'h000, 1'b0, 1'b1, 1'b0));
    exp_rd0.push_back(16'h5555);
    access(0, 1'b0, 11'h000, 16'h0000, s);
    drain();

    // 5: reset asserted during ISSUE of a read
    exp_ack.push_back(mk(0, 11'h005, 1'b0, 1'b1, 1'b0));
    @(posedge a_clk); #1;
    p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 11'h005;
    s0 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge a_clk);
      if (p0_ack) begin
        s0 = 1;
        break;
      end
    end
    check("t5_saw_ack", 32'(s0), 32'd1);
    #2 a_rst_n = 1'b0;
    p0_req = 1'b0;
    #1;
    check("t5_rst_ctrl", 32'({mem_ena, mem_wr, p0_ack, p1_ack, p0_rvalid, p1_rvalid, busy}),
          32'd0);
    check("t5_rst_addr", 32'(mem_addr), 32'd0);
    check("t5_rst_rdata", 32'(p0_rdata), 32'd0);
    @(negedge a_clk); #2 a_rst_n = 1'b1;
    repeat (6) @(negedge a_clk);
    check("t5_idle_busy", 32'(busy), 32'd0);
    exp_ack.push_back(mk(0, 11'h005, 1'b0, 1'b1, 1'b0));
    exp_rd0.push_back(16'hBEEF);
    access(0, 1'b0, 11'h005, 16'h0000, s);
    drain();

`ifdef GPMC_ARB_WP_EN
    // 6: protected port-0 write is acked but not performed
    exp_ack.push_back(mk(0, 11'h010, 1'b1, 1'b1, 1'b0));
    access(0, 1'b1, 11'h010, 16'h1111, s);
    wp = 1'b1;
    exp_ack.push_back(mk(0, 11'h010, 1'b0, 1'b0, 1'b1));
    access(0, 1'b1, 11'h010, 16'hAAAA, s);
    wp = 1'b0;
    exp_ack.push_back(mk(0, 11'h010, 1'b0, 1'b1, 1'b0));
    exp_rd0.push_back(16'h1111);
    access(0, 1'b0, 11'h010, 16'h0000, s);
    drain();
`endif

    repeat (3) @(negedge a_clk);
    check("final_queues", 32'(exp_ack.size() + exp_rd0.size() + exp_rd1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
